// File: rtl/axi4_safety_timeout_guard_pkg.sv
// Shared types and constants for the AXI4 safety timeout guard.
// The guard watches a single downstream slave port and fences it off if the slave stops making progress.
package axi4_safety_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int TIMER_W = 16;

    typedef logic [1:0] axi_burst_t;
    typedef logic [2:0] axi_size_t;

    typedef enum logic [2:0] {
        W_IDLE  = 3'd0,
        W_ADDR  = 3'd1,
        W_DATA  = 3'd2,
        W_RESP  = 3'd3,
        W_DRAIN = 3'd4,
        W_ERR   = 3'd5
    } wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2,
        R_ERR  = 2'd3
    } rd_state_e;

endpackage

// File: rtl/axi4_safety_timeout_guard_if.sv
// AXI4 channel bundle used on both sides of the guard. On every channel a beat transfers on a rising
// clock edge where valid and ready are both high; valid never waits for ready, and payload is held stable while valid is high.
interface axi4_safety_timeout_guard_if #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    import axi4_safety_pkg::*;

    logic                    awvalid;
    logic                    awready;
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    axi_size_t               awsize;
    axi_burst_t              awburst;

    logic                    wvalid;
    logic                    wready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;

    logic                    bvalid;
    logic                    bready;
    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;

    logic                    arvalid;
    logic                    arready;
    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    axi_size_t               arsize;
    axi_burst_t              arburst;

    logic                    rvalid;
    logic                    rready;
    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;

    modport master (
        output awvalid, awid, awaddr, awlen, awsize, awburst,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bid, bresp,
        output bready,
        output arvalid, arid, araddr, arlen, arsize, arburst,
        input  arready,
        input  rvalid, rid, rdata, rresp, rlast,
        output rready
    );

    modport slave (
        input  awvalid, awid, awaddr, awlen, awsize, awburst,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bid, bresp,
        input  bready,
        input  arvalid, arid, araddr, arlen, arsize, arburst,
        output arready,
        output rvalid, rid, rdata, rresp, rlast,
        input  rready
    );

endinterface

// File: rtl/axi4_safety_timeout_guard_timer.sv
// Saturating idle-cycle counter for one guard path.
// Clear has priority over enable, so a handshake on the expiry cycle restarts the count from zero.
module axi4_guard_timer
    import axi4_safety_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam logic [TIMER_W-1:0] LIMIT = TIMER_W'(TIMEOUT_CYCLES);

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != '1)) begin
            count_d = count_q + TIMER_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q >= LIMIT);

endmodule

// File: rtl/axi4_safety_timeout_guard.sv
// Per-port AXI4 guard: forwards one write and one read at a time, and on a slave stall completes the
// transaction upstream with SLVERR, then fences the slave and answers everything locally until reset.
module axi4_safety_timeout_guard
    import axi4_safety_pkg::*;
#(
    parameter int ID_WIDTH       = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                              clk,
    input  logic                              rst,
    axi4_safety_timeout_guard_if.slave        s_axi,
    axi4_safety_timeout_guard_if.master       m_axi,
    output logic                              fence,
    output logic                              wr_timeout,
    output logic                              rd_timeout,
    output wr_state_e                         dbg_wr_state_o,
    output rd_state_e                         dbg_rd_state_o
);

    localparam logic [DATA_WIDTH-1:0] ERR_DATA = '0;

    wr_state_e             wr_state_q, wr_state_d;
    rd_state_e             rd_state_q, rd_state_d;
    logic                  fence_q, fence_d;
    logic [7:0]            beat_cnt_q, beat_cnt_d;

    logic [ID_WIDTH-1:0]   aw_id_q;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [7:0]            aw_len_q;
    axi_size_t             aw_size_q;
    axi_burst_t            aw_burst_q;

    logic [ID_WIDTH-1:0]   ar_id_q;
    logic [ADDR_WIDTH-1:0] ar_addr_q;
    logic [7:0]            ar_len_q;
    axi_size_t             ar_size_q;
    axi_burst_t            ar_burst_q;

    logic wr_tmr_clear, wr_tmr_en, wr_expired, wr_to_evt;
    logic rd_tmr_clear, rd_tmr_en, rd_expired, rd_to_evt;
    logic s_aw_hs, s_ar_hs, s_r_hs;

    axi4_guard_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wr_timer (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (wr_tmr_clear),
        .enable_i  (wr_tmr_en),
        .expired_o (wr_expired)
    );

    axi4_guard_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rd_timer (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (rd_tmr_clear),
        .enable_i  (rd_tmr_en),
        .expired_o (rd_expired)
    );

    // Downstream request channels are replayed from the latch, data rides straight through.
    assign m_axi.awid    = aw_id_q;
    assign m_axi.awaddr  = aw_addr_q;
    assign m_axi.awlen   = aw_len_q;
    assign m_axi.awsize  = aw_size_q;
    assign m_axi.awburst = aw_burst_q;
    assign m_axi.wdata   = s_axi.wdata;
    assign m_axi.wstrb   = s_axi.wstrb;
    assign m_axi.wlast   = s_axi.wlast;
    assign m_axi.arid    = ar_id_q;
    assign m_axi.araddr  = ar_addr_q;
    assign m_axi.arlen   = ar_len_q;
    assign m_axi.arsize  = ar_size_q;
    assign m_axi.arburst = ar_burst_q;

    assign s_aw_hs = s_axi.awvalid && s_axi.awready;
    assign s_ar_hs = s_axi.arvalid && s_axi.arready;
    assign s_r_hs  = s_axi.rvalid && s_axi.rready;

    // Write path. A stalled W channel upstream does not age the timer; everything else waiting on the slave does.
    always_comb begin
        wr_state_d    = wr_state_q;
        wr_tmr_clear  = 1'b0;
        wr_tmr_en     = 1'b0;
        wr_to_evt     = 1'b0;
        s_axi.awready = 1'b0;
        m_axi.awvalid = 1'b0;
        s_axi.wready  = 1'b0;
        m_axi.wvalid  = 1'b0;
        s_axi.bvalid  = 1'b0;
        s_axi.bid     = aw_id_q;
        s_axi.bresp   = RESP_SLVERR;
        m_axi.bready  = fence_q;
        if (!rst) begin
            case (wr_state_q)
                W_IDLE: begin
                    s_axi.awready = 1'b1;
                    if (s_axi.awvalid) begin
                        wr_tmr_clear = 1'b1;
                        wr_state_d   = fence_q ? W_DRAIN : W_ADDR;
                    end
                end
                W_ADDR: begin
                    m_axi.awvalid = !fence_q;
                    wr_tmr_en     = 1'b1;
                    if (fence_q) begin
                        wr_state_d = W_DRAIN;
                    end else if (m_axi.awready) begin
                        wr_tmr_clear = 1'b1;
                        wr_state_d   = W_DATA;
                    end else if (wr_expired) begin
                        wr_to_evt  = 1'b1;
                        wr_state_d = W_DRAIN;
                    end
                end
                W_DATA: begin
                    m_axi.wvalid = s_axi.wvalid && !fence_q;
                    s_axi.wready = m_axi.wready && !fence_q;
                    wr_tmr_en    = s_axi.wvalid;
                    if (fence_q) begin
                        wr_state_d = W_DRAIN;
                    end else if (s_axi.wvalid && m_axi.wready) begin
                        wr_tmr_clear = 1'b1;
                        if (s_axi.wlast) begin
                            wr_state_d = W_RESP;
                        end
                    end else if (wr_expired) begin
                        wr_to_evt  = 1'b1;
                        wr_state_d = W_DRAIN;
                    end
                end
                W_RESP: begin
                    s_axi.bvalid = m_axi.bvalid && !fence_q;
                    s_axi.bid    = m_axi.bid;
                    s_axi.bresp  = m_axi.bresp;
                    m_axi.bready = fence_q || s_axi.bready;
                    wr_tmr_en    = 1'b1;
                    if (fence_q) begin
                        wr_state_d = W_ERR;
                    end else if (m_axi.bvalid && s_axi.bready) begin
                        wr_tmr_clear = 1'b1;
                        wr_state_d   = W_IDLE;
                    end else if (wr_expired) begin
                        wr_to_evt  = 1'b1;
                        wr_state_d = W_ERR;
                    end
                end
                W_DRAIN: begin
                    s_axi.wready = 1'b1;
                    if (s_axi.wvalid && s_axi.wlast) begin
                        wr_state_d = W_ERR;
                    end
                end
                W_ERR: begin
                    s_axi.bvalid = 1'b1;
                    if (s_axi.bready) begin
                        wr_state_d = W_IDLE;
                    end
                end
                default: wr_state_d = W_IDLE;
            endcase
        end
    end

    // Read path. The error burst length comes from the shared beat counter, so only the missing beats are sent.
    always_comb begin
        rd_state_d    = rd_state_q;
        rd_tmr_clear  = 1'b0;
        rd_tmr_en     = 1'b0;
        rd_to_evt     = 1'b0;
        s_axi.arready = 1'b0;
        m_axi.arvalid = 1'b0;
        s_axi.rvalid  = 1'b0;
        s_axi.rid     = ar_id_q;
        s_axi.rdata   = ERR_DATA;
        s_axi.rresp   = RESP_SLVERR;
        s_axi.rlast   = 1'b0;
        m_axi.rready  = fence_q;
        if (!rst) begin
            case (rd_state_q)
                R_IDLE: begin
                    s_axi.arready = 1'b1;
                    if (s_axi.arvalid) begin
                        rd_tmr_clear = 1'b1;
                        rd_state_d   = fence_q ? R_ERR : R_ADDR;
                    end
                end
                R_ADDR: begin
                    m_axi.arvalid = !fence_q;
                    rd_tmr_en     = 1'b1;
                    if (fence_q) begin
                        rd_state_d = R_ERR;
                    end else if (m_axi.arready) begin
                        rd_tmr_clear = 1'b1;
                        rd_state_d   = R_DATA;
                    end else if (rd_expired) begin
                        rd_to_evt  = 1'b1;
                        rd_state_d = R_ERR;
                    end
                end
                R_DATA: begin
                    s_axi.rvalid = m_axi.rvalid && !fence_q;
                    s_axi.rid    = m_axi.rid;
                    s_axi.rdata  = m_axi.rdata;
                    s_axi.rresp  = m_axi.rresp;
                    s_axi.rlast  = m_axi.rlast;
                    m_axi.rready = fence_q || s_axi.rready;
                    rd_tmr_en    = 1'b1;
                    if (fence_q) begin
                        rd_state_d = R_ERR;
                    end else if (m_axi.rvalid && s_axi.rready) begin
                        rd_tmr_clear = 1'b1;
                        if (m_axi.rlast) begin
                            rd_state_d = R_IDLE;
                        end
                    end else if (rd_expired) begin
                        rd_to_evt  = 1'b1;
                        rd_state_d = R_ERR;
                    end
                end
                R_ERR: begin
                    s_axi.rvalid = 1'b1;
                    s_axi.rlast  = (beat_cnt_q == ar_len_q);
                    if (s_axi.rready && (beat_cnt_q == ar_len_q)) begin
                        rd_state_d = R_IDLE;
                    end
                end
                default: rd_state_d = R_IDLE;
            endcase
        end
    end

    always_comb begin
        fence_d    = fence_q || wr_to_evt || rd_to_evt;
        beat_cnt_d = beat_cnt_q;
        if (s_ar_hs) begin
            beat_cnt_d = '0;
        end else if (s_r_hs) begin
            beat_cnt_d = beat_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_q <= W_IDLE;
            rd_state_q <= R_IDLE;
            fence_q    <= 1'b0;
            beat_cnt_q <= '0;
            aw_id_q    <= '0;
            aw_addr_q  <= '0;
            aw_len_q   <= '0;
            aw_size_q  <= '0;
            aw_burst_q <= '0;
            ar_id_q    <= '0;
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            ar_size_q  <= '0;
            ar_burst_q <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            fence_q    <= fence_d;
            beat_cnt_q <= beat_cnt_d;
            if (s_aw_hs) begin
                aw_id_q    <= s_axi.awid;
                aw_addr_q  <= s_axi.awaddr;
                aw_len_q   <= s_axi.awlen;
                aw_size_q  <= s_axi.awsize;
                aw_burst_q <= s_axi.awburst;
            end
            if (s_ar_hs) begin
                ar_id_q    <= s_axi.arid;
                ar_addr_q  <= s_axi.araddr;
                ar_len_q   <= s_axi.arlen;
                ar_size_q  <= s_axi.arsize;
                ar_burst_q <= s_axi.arburst;
            end
        end
    end

    assign fence          = fence_q;
    assign wr_timeout     = wr_to_evt;
    assign rd_timeout     = rd_to_evt;
    assign dbg_wr_state_o = wr_state_q;
    assign dbg_rd_state_o = rd_state_q;

endmodule
